// File: rtl/key_cfg_ctrl.sv
// Front-panel key controller: turns three debounced active-low keys into frequency-word
// and waveform-select updates, delivered to the DDS over a valid/ready handshake.
module key_cfg_ctrl #(
   parameter int unsigned     FW_W     = 32,
   parameter logic [FW_W-1:0] FW_INIT  = 42950,
   parameter logic [FW_W-1:0] FW_STEP  = 42950,
   parameter logic [FW_W-1:0] FW_MIN   = '0,
   parameter logic [FW_W-1:0] FW_MAX   = '1,
   parameter int unsigned     LONG_CYC = 50000000,
   parameter int unsigned     REP_CYC  = 10000000,
   parameter int unsigned     NWAVE    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            key_up_n,
   input  logic            key_dn_n,
   input  logic            key_mode_n,
   input  logic            cfg_ready,
   output logic            cfg_valid,
   output logic [FW_W-1:0] freq_word,
   output logic [1:0]      wave_sel,
   output logic            key_busy
);

   localparam int unsigned TMR_MAX = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH,
      S_HOLD,
      S_REPEAT,
      S_WAIT_REL
   } state_t;

   typedef enum logic [1:0] {
      K_UP,
      K_DN,
      K_MODE
   } key_t;

   // Key vectors are packed {mode, down, up}.
   logic [2:0] sync1_q, sync2_q, hist_q;
   logic [2:0] press;
   logic       all_rel;

   state_t            state_q, ret_q;
   key_t              sel_q;
   logic [TMR_W-1:0]  timer_q;
   logic [FW_W-1:0]   fw_q;
   logic [1:0]        ws_q;
   logic              valid_q;

   logic              step_up;
   logic              sel_held;
   logic              tmr_hit;
   logic [FW_W:0]     up_sum;
   logic [FW_W-1:0]   fw_d;
   logic              fw_change;
   logic [1:0]        ws_d;

   // Synchronizers preset to 1 so a reset never fabricates a press edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
         hist_q  <= '1;
      end else begin
         // NOTE: non-blocking assignments let this shift chain advance one stage per clock;
         // blocking ones would collapse the three flops into a single stage.
         sync1_q <= {key_mode_n, key_dn_n, key_up_n};
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   assign press   = ~sync2_q & hist_q;
   assign all_rel = &sync2_q;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      step_up  = 1'b0;
      sel_held = 1'b0;
      tmr_hit  = 1'b0;
      fw_d     = fw_q;
      ws_d     = ws_q;

      if (state_q == S_IDLE) begin
         step_up = press[0];
      end else begin
         step_up = (sel_q == K_UP);
      end

      case (sel_q)
         K_UP:    sel_held = ~sync2_q[0];
         K_DN:    sel_held = ~sync2_q[1];
         default: sel_held = ~sync2_q[2];
      endcase

      if (state_q == S_HOLD) begin
         tmr_hit = (timer_q == TMR_W'(LONG_CYC - 1));
      end else begin
         tmr_hit = (timer_q == TMR_W'(REP_CYC - 1));
      end

      // One extra bit keeps the sum from wrapping before the clamp is applied.
      up_sum = {1'b0, fw_q} + {1'b0, FW_STEP};
      if (step_up) begin
         if (up_sum > {1'b0, FW_MAX}) begin
            fw_d = FW_MAX;
         end else begin
            fw_d = up_sum[FW_W-1:0];
         end
      end else begin
         if ({1'b0, fw_q} < ({1'b0, FW_MIN} + {1'b0, FW_STEP})) begin
            fw_d = FW_MIN;
         end else begin
            fw_d = fw_q - FW_STEP;
         end
      end

      if (ws_q == 2'(NWAVE - 1)) begin
         ws_d = '0;
      end else begin
         ws_d = ws_q + 2'd1;
      end
   end

   assign fw_change = (fw_d != fw_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ret_q   <= S_HOLD;
         sel_q   <= K_UP;
         timer_q <= '0;
         fw_q    <= FW_INIT;
         ws_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               timer_q <= '0;
               if (press[0] || press[1]) begin
                  sel_q <= press[0] ? K_UP : K_DN;
                  if (fw_change) begin
                     fw_q    <= fw_d;
                     valid_q <= 1'b1;
                     ret_q   <= S_HOLD;
                     state_q <= S_PUSH;
                  end else begin
                     state_q <= S_HOLD;
                  end
               end else if (press[2]) begin
                  sel_q   <= K_MODE;
                  ws_q    <= ws_d;
                  valid_q <= 1'b1;
                  ret_q   <= S_WAIT_REL;
                  state_q <= S_PUSH;
               end
            end

            // Held until the DDS takes the update; a release here is seen afterwards.
            S_PUSH: begin
               if (cfg_ready) begin
                  valid_q <= 1'b0;
                  timer_q <= '0;
                  state_q <= ret_q;
               end
            end

            S_HOLD, S_REPEAT: begin
               if (!sel_held) begin
                  timer_q <= '0;
                  state_q <= S_WAIT_REL;
               end else if (tmr_hit) begin
                  timer_q <= '0;
                  if (fw_change) begin
                     fw_q    <= fw_d;
                     valid_q <= 1'b1;
                     ret_q   <= S_REPEAT;
                     state_q <= S_PUSH;
                  end
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end

            S_WAIT_REL: begin
               timer_q <= '0;
               if (all_rel) begin
                  state_q <= S_IDLE;
               end
            end

            default: begin
               timer_q <= '0;
               valid_q <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cfg_valid = valid_q;
   assign freq_word = fw_q;
   assign wave_sel  = ws_q;
   assign key_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_key_cfg_ctrl.sv
// Self-checking bench for key_cfg_ctrl: vector table, hand-timed corner sequences and a
// randomized tap run scored against a transaction-level model.
module tb_key_cfg_ctrl;

   localparam int unsigned FW_W = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            key_up_n = 1'b1;
   logic            key_dn_n = 1'b1;
   logic            key_mode_n = 1'b1;
   logic            cfg_ready = 1'b1;
   logic            cfg_valid;
   logic [FW_W-1:0] freq_word;
   logic [1:0]      wave_sel;
   logic            key_busy;

   key_cfg_ctrl #(
      .FW_W     (32),
      .FW_INIT  (32'd100),
      .FW_STEP  (32'd10),
      .FW_MIN   (32'd0),
      .FW_MAX   (32'd130),
      .LONG_CYC (20),
      .REP_CYC  (5),
      .NWAVE    (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_up_n   (key_up_n),
      .key_dn_n   (key_dn_n),
      .key_mode_n (key_mode_n),
      .cfg_ready  (cfg_ready),
      .cfg_valid  (cfg_valid),
      .freq_word  (freq_word),
      .wave_sel   (wave_sel),
      .key_busy   (key_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        up;
      logic        dn;
      logic        md;
      int          hold;
      logic [31:0] fw;
      logic [1:0]  ws;
      int          txn;
   } vec_t;

   typedef struct {
      logic [31:0] fw;
      logic [1:0]  ws;
   } txn_t;

   int   checks = 0;
   int   errors = 0;
   int   hs_cnt = 0;
   int   vhigh_cnt = 0;
   int   stab_err = 0;
   logic sb_en = 1'b0;
   logic rnd_ready = 1'b0;
   logic stall_q = 1'b0;
   logic [31:0] prev_fw = '0;
   logic [1:0]  prev_ws = '0;
   txn_t obs_q[$];
   txn_t exp_q[$];
   vec_t vecs[13];

   // Observes the DDS side at the falling edge, half a cycle clear of any update.
   always @(negedge clk) begin
      if (rst) begin
         stall_q <= 1'b0;
      end else begin
         if (cfg_valid) vhigh_cnt <= vhigh_cnt + 1;
         if (cfg_valid && cfg_ready) begin
            hs_cnt <= hs_cnt + 1;
            if (sb_en) obs_q.push_back('{fw: freq_word, ws: wave_sel});
         end
         if (stall_q && (!cfg_valid || freq_word != prev_fw || wave_sel != prev_ws))
            stab_err <= stab_err + 1;
         stall_q <= cfg_valid && !cfg_ready;
         prev_fw <= freq_word;
         prev_ws <= wave_sel;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (rnd_ready) cfg_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic set_keys(input logic up, input logic dn, input logic md);
      key_up_n   = ~up;
      key_dn_n   = ~dn;
      key_mode_n = ~md;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!key_busy) break;
         cyc();
      end
      check("idle_wait", {31'd0, key_busy}, 32'd0);
   endtask

   task automatic do_reset();
      set_keys(1'b0, 1'b0, 1'b0);
      cfg_ready = 1'b1;
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(2);
   endtask

   // Press a key pattern for hold cycles, release, and wait for the FSM to settle.
   task automatic tap(input logic up, input logic dn, input logic md, input int hold);
      set_keys(up, dn, md);
      cyc(hold);
      set_keys(1'b0, 1'b0, 1'b0);
      cyc(3);
      wait_idle(300);
      cyc(2);
   endtask

   initial begin
      int   hs0, vh0;
      logic [31:0] m_fw;
      logic [1:0]  m_ws;
      logic [2:0]  pat;
      logic [31:0] nxt;

      vecs[0]  = '{1'b1, 1'b0, 1'b0, 3, 32'd110, 2'd0, 1};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 8, 32'd120, 2'd0, 1};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 2, 32'd110, 2'd0, 1};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 4, 32'd110, 2'd1, 1};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 5, 32'd120, 2'd1, 1};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 3, 32'd110, 2'd1, 1};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 3, 32'd120, 2'd1, 1};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 2, 32'd130, 2'd1, 1};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 2, 32'd130, 2'd1, 0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1, 32'd130, 2'd2, 1};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 2, 32'd130, 2'd3, 1};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 6, 32'd130, 2'd0, 1};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 3, 32'd130, 2'd1, 1};

      // Reset state.
      cyc(2);
      check("rst_fw", freq_word, 32'd100);
      check("rst_ws", {30'd0, wave_sel}, 32'd0);
      check("rst_valid", {31'd0, cfg_valid}, 32'd0);
      check("rst_busy", {31'd0, key_busy}, 32'd0);
      rst = 1'b0;
      cyc(2);

      // Single UP tap: update lands on the third edge, valid lasts one cycle.
      vh0 = vhigh_cnt;
      set_keys(1'b1, 1'b0, 1'b0);
      cyc(2);
      check("lat_edge2_fw", freq_word, 32'd100);
      check("lat_edge2_valid", {31'd0, cfg_valid}, 32'd0);
      cyc();
      check("lat_edge3_fw", freq_word, 32'd110);
      check("lat_edge3_valid", {31'd0, cfg_valid}, 32'd1);
      check("lat_edge3_busy", {31'd0, key_busy}, 32'd1);
      cyc();
      check("lat_edge4_valid", {31'd0, cfg_valid}, 32'd0);
      cyc(4);
      set_keys(1'b0, 1'b0, 1'b0);
      wait_idle(50);
      check("tap_valid_cycles", vhigh_cnt - vh0, 32'd1);

      // Vector table from a fresh reset.
      do_reset();
      foreach (vecs[i]) begin
         hs0 = hs_cnt;
         tap(vecs[i].up, vecs[i].dn, vecs[i].md, vecs[i].hold);
         check($sformatf("vec%0d_fw", i), freq_word, vecs[i].fw);
         check($sformatf("vec%0d_ws", i), {30'd0, wave_sel}, {30'd0, vecs[i].ws});
         check($sformatf("vec%0d_txn", i), hs_cnt - hs0, vecs[i].txn);
      end

      // UP held 50 cycles: steps at the third edge, after the long hold, then every repeat.
      do_reset();
      hs0 = hs_cnt;
      set_keys(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 50; k++) begin
         cyc();
         if (k == 23) check("hold_e23_fw", freq_word, 32'd110);
         if (k == 24) check("hold_e24_fw", freq_word, 32'd120);
         if (k == 29) check("rep_e29_fw", freq_word, 32'd120);
         if (k == 30) check("rep_e30_fw", freq_word, 32'd130);
      end
      set_keys(1'b0, 1'b0, 1'b0);
      wait_idle(50);
      check("hold_fw_final", freq_word, 32'd130);
      check("hold_txn", hs_cnt - hs0, 32'd3);

      // DOWN held down to the floor, then a DOWN tap at the floor.
      do_reset();
      hs0 = hs_cnt;
      set_keys(1'b0, 1'b1, 1'b0);
      cyc(100);
      set_keys(1'b0, 1'b0, 1'b0);
      wait_idle(50);
      check("down_floor_fw", freq_word, 32'd0);
      check("down_floor_txn", hs_cnt - hs0, 32'd10);
      hs0 = hs_cnt;
      vh0 = vhigh_cnt;
      tap(1'b0, 1'b1, 1'b0, 4);
      check("min_tap_fw", freq_word, 32'd0);
      check("min_tap_valid", vhigh_cnt - vh0, 32'd0);

      // MODE held long: one step only.
      hs0 = hs_cnt;
      tap(1'b0, 1'b0, 1'b1, 100);
      check("mode_hold_txn", hs_cnt - hs0, 32'd1);
      check("mode_hold_ws", {30'd0, wave_sel}, 32'd1);

      // UP and DOWN together; DOWN stays held after UP release and must be ignored.
      do_reset();
      hs0 = hs_cnt;
      set_keys(1'b1, 1'b1, 1'b0);
      cyc(5);
      set_keys(1'b0, 1'b1, 1'b0);
      cyc(10);
      check("pair_busy", {31'd0, key_busy}, 32'd1);
      check("pair_fw_mid", freq_word, 32'd110);
      set_keys(1'b0, 1'b0, 1'b0);
      cyc(3);
      wait_idle(50);
      check("pair_fw", freq_word, 32'd110);
      check("pair_txn", hs_cnt - hs0, 32'd1);

      // Backpressure: seven stalled cycles with a release in the middle, then one ready edge.
      do_reset();
      cfg_ready = 1'b0;
      set_keys(1'b1, 1'b0, 1'b0);
      cyc(3);
      check("bp_valid", {31'd0, cfg_valid}, 32'd1);
      for (int k = 0; k < 7; k++) begin
         cyc();
         if (k == 3) set_keys(1'b0, 1'b0, 1'b0);
         check("bp_hold_fw", freq_word, 32'd110);
      end
      check("bp_stall_valid", {31'd0, cfg_valid}, 32'd1);
      cfg_ready = 1'b1;
      cyc();
      check("bp_release_valid", {31'd0, cfg_valid}, 32'd0);
      wait_idle(50);
      check("bp_fw", freq_word, 32'd110);
      check("bp_stable", stab_err, 32'd0);

      // Reset in the middle of a stalled update.
      tap(1'b0, 1'b0, 1'b1, 2);
      cfg_ready = 1'b0;
      set_keys(1'b1, 1'b0, 1'b0);
      cyc(3);
      check("rstp_valid_pre", {31'd0, cfg_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rstp_fw", freq_word, 32'd100);
      check("rstp_ws", {30'd0, wave_sel}, 32'd0);
      check("rstp_valid", {31'd0, cfg_valid}, 32'd0);
      check("rstp_busy", {31'd0, key_busy}, 32'd0);
      set_keys(1'b0, 1'b0, 1'b0);
      cfg_ready = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(2);

      // Randomized taps with random backpressure against a transaction-level model.
      do_reset();
      m_fw = 32'd100;
      m_ws = 2'd0;
      obs_q.delete();
      exp_q.delete();
      sb_en = 1'b1;
      rnd_ready = 1'b1;
      for (int t = 0; t < 60; t++) begin
         pat = 3'($urandom_range(1, 7));
         if (pat[0] || pat[1]) begin
            if (pat[0]) nxt = (m_fw + 10 > 130) ? 32'd130 : m_fw + 10;
            else        nxt = (m_fw < 10) ? 32'd0 : m_fw - 10;
            if (nxt != m_fw) begin
               m_fw = nxt;
               exp_q.push_back('{fw: m_fw, ws: m_ws});
            end
         end else begin
            m_ws = 2'((m_ws + 1) % 4);
            exp_q.push_back('{fw: m_fw, ws: m_ws});
         end
         tap(pat[0], pat[1], pat[2], $urandom_range(1, 10));
      end
      rnd_ready = 1'b0;
      cfg_ready = 1'b1;
      cyc(2);
      sb_en = 1'b0;
      check("rnd_txn_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check($sformatf("rnd_txn%0d_fw", i), obs_q[i].fw, exp_q[i].fw);
         check($sformatf("rnd_txn%0d_ws", i), {30'd0, obs_q[i].ws}, {30'd0, exp_q[i].ws});
      end
      check("rnd_final_fw", freq_word, m_fw);
      check("rnd_final_ws", {30'd0, wave_sel}, {30'd0, m_ws});
      check("rnd_stable", stab_err, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_cfg_ctrl.md
Name: key_cfg_ctrl

Overview:
Front-panel controller between the debounced key outputs and the DDS/DAC datapath. It turns three debounced, active-low key levels (UP, DOWN, MODE) into configuration updates: a frequency tuning word with step, clamp and long-press auto-repeat, and a waveform select.
- Each update goes to the DDS through a valid/ready handshake.
- Arbitration: one key is serviced at a time, with fixed priority.

Parameters:
FW_W, 32, frequency word width
FW_INIT, 42950, reset value of freq_word (~1 kHz at 100 MHz, 32-bit phase accumulator)
FW_STEP, 42950, increment/decrement per step
FW_MIN, 0, lower clamp
FW_MAX, 4294967295, upper clamp
LONG_CYC, 50000000, hold cycles before auto-repeat starts (0.5 s at 100 MHz)
REP_CYC, 10000000, cycles between auto-repeat steps (100 ms)
NWAVE, 4, number of waveforms; wave_sel wraps modulo NWAVE

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
key_up_n  in  1  debounced UP level, 0 = pressed
key_dn_n  in  1  debounced DOWN level, 0 = pressed
key_mode_n  in  1  debounced MODE level, 0 = pressed
cfg_ready  in  1  DDS accepts the update when high with cfg_valid
cfg_valid  out  1  update pending
freq_word  out  FW_W  current tuning word
wave_sel  out  2  current waveform index
key_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (asynchronous, immediate on rst rise): freq_word=FW_INIT, wave_sel=0, cfg_valid=0, key_busy=0, FSM=IDLE, timers=0. Sync flops preset to 1 (released).
- Input path:
  - Each key passes through a 2-flop synchronizer plus one history flop.
  - Press edge = synced 0 while history 1.
  - Latency: freq_word/wave_sel update and cfg_valid rise take effect at the 3rd rising clk edge after the key input falls.
- FSM states: IDLE, PUSH, HOLD, REPEAT, WAIT_REL.
- IDLE:
  - On a press edge, select the key by priority UP > DOWN > MODE. Other keys are ignored until all keys are released.
  - UP/DOWN: compute next = freq_word ± FW_STEP, clamped to [FW_MIN, FW_MAX] with FW_W+1-bit arithmetic (no wrap).
  - If next != freq_word: load it, set cfg_valid, go to PUSH (return target HOLD).
  - If equal (already at the clamp): no transaction, go to HOLD.
  - MODE: wave_sel = (wave_sel+1) mod NWAVE, set cfg_valid, go to PUSH (return target WAIT_REL).
- PUSH:
  - cfg_valid stays high; freq_word and wave_sel stay stable until cfg_valid && cfg_ready is sampled high on a clk edge.
  - At that edge: cfg_valid drops, the timer clears, and the FSM goes to the return target.
  - Key release during PUSH does not abort; the release is evaluated after the handshake.
- HOLD:
  - The timer counts while the selected key is held.
  - At count == LONG_CYC-1: perform one step (same rules as IDLE), with return target REPEAT.
  - Release of the selected key → WAIT_REL.
- REPEAT: same as HOLD, but steps at count == REP_CYC-1.
- Clamp during HOLD/REPEAT: a step that produces no change issues no transaction; the FSM stays in the same state and the timer clears.
- WAIT_REL: when all three synced keys read 1 → IDLE.
- Pressing a second key while one is held has no effect.
- cfg_ready high outside PUSH is ignored.
- Timer width: ceil(log2(max(LONG_CYC, REP_CYC))) bits. The timer never wraps; it clears on every state change.

Test Plan:
(LONG_CYC=20, REP_CYC=5, FW_STEP=10, FW_INIT=100, FW_MAX=130, cfg_ready tied 1 unless stated)
1. Single UP tap for 8 cycles → freq_word=110 at 3rd edge after press; cfg_valid high exactly 1 cycle; key_busy returns to 0 after release.
2. UP held 50 cycles, ready=1 → steps at press, +~20, then every ~5 cycles; freq_word stops at 130; no cfg_valid once clamped.
3. DOWN from FW_MIN=0 → no cfg_valid; freq_word stays 0.
4. UP and DOWN fall in the same cycle → only +10 applied; DOWN ignored until both released.
5. MODE pressed 5 times → wave_sel sequence 1, 2, 3, 0, 1; no auto-repeat when MODE is held 100 cycles.
6. Backpressure and reset:
   - cfg_ready=0 for 7 cycles after an UP press → cfg_valid and freq_word held stable; the handshake completes on the first ready edge.
   - rst asserted mid-PUSH → outputs immediately return to reset values.
